// File: rtl/kbd_receiver_pkg.sv
// PS/2 keyboard receiver shared definitions.
// KCON bit positions and receiver FSM encodings.
package kbd_receiver_pkg;

  localparam int KEN = 0;
  localparam int KIE = 1;
  localparam int KRF = 2;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_DATA   = 2'd1;
  localparam logic [1:0] ST_PARITY = 2'd2;
  localparam logic [1:0] ST_STOP   = 2'd3;

  // Odd parity over data plus parity bit is a good frame.
  function automatic logic parity_ok(
    input logic [7:0] d,
    input logic       p
  );
    return ^{d, p};
  endfunction

endpackage

// File: rtl/kbd_receiver_sync.sv
// PS/2 clock/data synchroniser and registered falling-edge detector.
// Flops reset to the idle bus level so reset never fakes an edge.
module ps2_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_ps2_clk,
  input  logic i_ps2_data,
  output logic fe,
  output logic data
);

  logic [SYNC_STAGES-1:0] clk_q;
  logic [SYNC_STAGES-1:0] data_q;
  logic                   clk_prev;
  logic                   clk_s;

  assign clk_s = clk_q[SYNC_STAGES-1];

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      clk_q    <= '1;
      data_q   <= '1;
      clk_prev <= 1'b1;
      fe       <= 1'b0;
      data     <= 1'b1;
    end else begin
      clk_q[0]  <= i_ps2_clk;
      data_q[0] <= i_ps2_data;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        clk_q[i]  <= clk_q[i-1];
        data_q[i] <= data_q[i-1];
      end
      clk_prev <= clk_s;
      // data is delayed one stage so it lines up with fe
      fe       <= clk_prev & ~clk_s;
      data     <= data_q[SYNC_STAGES-1];
    end
  end

endmodule

// File: rtl/kbd_receiver.sv
// PS/2 keyboard receiver: frame FSM, timeout and status strobes.
// Accepted scan codes land in o_kbuf; errors leave it untouched.
module kbd_receiver
  import kbd_receiver_pkg::*;
#(
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 12000
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [7:0] i_kcon,
  input  logic       i_ps2_clk,
  input  logic       i_ps2_data,
  output logic [7:0] o_kbuf,
  output logic       o_rx_pulse,
  output logic       o_perr,
  output logic       o_ferr,
  output logic       o_ovr,
  output logic       o_busy,
  output logic       o_irq
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic          fe;
  logic          data;
  logic [1:0]    state;
  logic [2:0]    bit_cnt;
  logic [TW-1:0] tmo_cnt;
  logic [7:0]    shreg;
  logic          par;
  logic          tmo_hit;
  logic          kcon_unused;

  ps2_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_ps2_clk (i_ps2_clk),
    .i_ps2_data(i_ps2_data),
    .fe        (fe),
    .data      (data)
  );

  // Fires so the ferr strobe lands TIMEOUT_CYCLES after the last fe cycle.
  assign tmo_hit     = (tmo_cnt == TW'(TIMEOUT_CYCLES - 2));
  assign o_busy      = (state != ST_IDLE);
  assign o_irq       = i_kcon[KIE] & i_kcon[KRF];
  assign kcon_unused = ^i_kcon[7:3];

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state      <= ST_IDLE;
      bit_cnt    <= '0;
      tmo_cnt    <= '0;
      shreg      <= '0;
      par        <= 1'b0;
      o_kbuf     <= '0;
      o_rx_pulse <= 1'b0;
      o_perr     <= 1'b0;
      o_ferr     <= 1'b0;
      o_ovr      <= 1'b0;
    end else begin
      o_rx_pulse <= 1'b0;
      o_perr     <= 1'b0;
      o_ferr     <= 1'b0;
      o_ovr      <= 1'b0;
      if (!i_kcon[KEN]) begin
        state   <= ST_IDLE;
        bit_cnt <= '0;
        tmo_cnt <= '0;
      end else if (state != ST_IDLE && !fe && tmo_hit) begin
        state   <= ST_IDLE;
        bit_cnt <= '0;
        tmo_cnt <= '0;
        o_ferr  <= 1'b1;
      end else begin
        if (fe || state == ST_IDLE) tmo_cnt <= '0;
        else                        tmo_cnt <= tmo_cnt + 1'b1;
        if (fe) begin
          unique case (state)
            ST_IDLE: begin
              if (!data) begin
                state   <= ST_DATA;
                bit_cnt <= '0;
              end
            end
            ST_DATA: begin
              shreg   <= {data, shreg[7:1]};
              bit_cnt <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) state <= ST_PARITY;
            end
            ST_PARITY: begin
              par   <= data;
              state <= ST_STOP;
            end
            ST_STOP: begin
              state <= ST_IDLE;
              if (!data)                       o_ferr <= 1'b1;
              else if (!parity_ok(shreg, par)) o_perr <= 1'b1;
              else if (i_kcon[KRF])            o_ovr  <= 1'b1;
              else begin
                o_kbuf     <= shreg;
                o_rx_pulse <= 1'b1;
              end
            end
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_kbd_receiver.sv
// Directed bench for kbd_receiver with a strobe scoreboard.
module tb_kbd_receiver;

  localparam int HALF = 6;

  localparam logic [3:0] C_RX = 4'b1000;
  localparam logic [3:0] C_PE = 4'b0100;
  localparam logic [3:0] C_FE = 4'b0010;
  localparam logic [3:0] C_OV = 4'b0001;

  typedef struct packed {
    logic [3:0] code;
    logic [7:0] kbuf;
  } ev_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] kcon = 8'h01;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic [7:0] o_kbuf;
  logic       o_rx_pulse, o_perr, o_ferr, o_ovr, o_busy, o_irq;
  logic [3:0] strb;

  ev_t        sb[$];
  int         n_cmp = 0;
  int         n_err = 0;
  logic [7:0] kbuf_m = 8'h00;

  assign strb = {o_rx_pulse, o_perr, o_ferr, o_ovr};

  kbd_receiver #(
    .SYNC_STAGES   (2),
    .TIMEOUT_CYCLES(100)
  ) dut (
    .i_clk     (clk),
    .i_rst     (rst),
    .i_kcon    (kcon),
    .i_ps2_clk (ps2_clk),
    .i_ps2_data(ps2_data),
    .o_kbuf    (o_kbuf),
    .o_rx_pulse(o_rx_pulse),
    .o_perr    (o_perr),
    .o_ferr    (o_ferr),
    .o_ovr     (o_ovr),
    .o_busy    (o_busy),
    .o_irq     (o_irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    ev_t e;
    if (!rst && strb != 4'b0000) begin
      check("onehot", $countones(strb), 1);
      if (sb.size() == 0) begin
        check("unexpected_strobe", {28'd0, strb}, 0);
      end else begin
        e = sb.pop_front();
        check("sb_code", {28'd0, strb}, {28'd0, e.code});
        check("sb_kbuf", {24'd0, o_kbuf}, {24'd0, e.kbuf});
      end
    end
  end

  task automatic ps2_bit(input logic b);
    @(negedge clk);
    ps2_data = b;
    repeat (HALF) @(negedge clk);
    ps2_clk = 1'b0;
    repeat (HALF) @(negedge clk);
    ps2_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic p,
                            input logic s);
    logic [3:0] ec;
    if (!s)                  ec = C_FE;
    else if (^{d, p} == 1'b0) ec = C_PE;
    else if (kcon[2])        ec = C_OV;
    else begin
      ec     = C_RX;
      kbuf_m = d;
    end
    sb.push_back(ev_t'{code: ec, kbuf: kbuf_m});
    ps2_bit(1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(d[i]);
    ps2_bit(p);
    @(negedge clk);
    ps2_data = s;
    repeat (HALF) @(negedge clk);
    ps2_clk = 1'b0;
    repeat (3) @(posedge clk);
    #1 check("pre_strobe", {28'd0, strb}, 0);
    @(posedge clk);
    #1 check("stop_latency", {28'd0, strb}, {28'd0, ec});
    @(posedge clk);
    #1 check("strobe_width", {28'd0, strb}, 0);
    repeat (HALF) @(negedge clk);
    ps2_clk = 1'b1;
    repeat (HALF) @(negedge clk);
    ps2_data = 1'b1;
    check("kbuf_after", {24'd0, o_kbuf}, {24'd0, kbuf_m});
    check("busy_after", {31'd0, o_busy}, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    bit seen;
    rst  = 1'b1;
    kcon = 8'h01;
    repeat (3) @(posedge clk);
    #1;
    check("rst_kbuf", {24'd0, o_kbuf}, 0);
    check("rst_busy", {31'd0, o_busy}, 0);
    check("rst_strobes", {28'd0, strb}, 0);
    check("rst_irq", {31'd0, o_irq}, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (5) @(posedge clk);
    #1 check("no_fe_after_rst", {31'd0, o_busy}, 0);

    // fe with data high in IDLE is ignored
    @(negedge clk);
    ps2_data = 1'b1;
    ps2_clk  = 1'b0;
    repeat (4) @(posedge clk);
    #1 check("idle_high_fe", {31'd0, o_busy}, 0);
    repeat (HALF) @(negedge clk);
    ps2_clk = 1'b1;
    repeat (HALF) @(negedge clk);

    send_frame(8'h1C, 1'b0, 1'b1);
    send_frame(8'hF0, 1'b0, 1'b1);
    send_frame(8'h1C, 1'b0, 1'b0);

    // stall mid-frame after four data bits
    ps2_bit(1'b0);
    ps2_bit(1'b1);
    ps2_bit(1'b0);
    ps2_bit(1'b1);
    @(negedge clk);
    ps2_data = 1'b1;
    repeat (HALF) @(negedge clk);
    ps2_clk = 1'b0;
    sb.push_back(ev_t'{code: C_FE, kbuf: kbuf_m});
    check("tmo_busy_before", {31'd0, o_busy}, 1);
    cyc  = 0;
    seen = 1'b0;
    for (int k = 1; k <= 300 && !seen; k++) begin
      @(posedge clk);
      #1;
      if (o_ferr) begin
        seen = 1'b1;
        cyc  = k;
      end
    end
    // two sync stages + edge register put the fe cycle at edge 3
    check("tmo_cycles", cyc, 103);
    check("tmo_busy_after", {31'd0, o_busy}, 0);
    repeat (HALF) @(negedge clk);
    ps2_clk = 1'b1;
    repeat (HALF) @(negedge clk);

    kcon = 8'h07;
    @(negedge clk);
    check("irq_set", {31'd0, o_irq}, 1);
    send_frame(8'h32, 1'b0, 1'b1);
    kcon = 8'h05;
    #1 check("irq_kie0", {31'd0, o_irq}, 0);
    kcon = 8'h03;
    #1 check("irq_krf0", {31'd0, o_irq}, 0);
    kcon = 8'h01;

    send_frame(8'h5A, 1'b1, 1'b1);

    // KEN drop mid-frame
    ps2_bit(1'b0);
    ps2_bit(1'b1);
    ps2_bit(1'b0);
    @(negedge clk);
    check("ken_busy_before", {31'd0, o_busy}, 1);
    kcon = 8'h00;
    @(posedge clk);
    #1 check("ken_busy_after", {31'd0, o_busy}, 0);
    repeat (30) @(negedge clk);
    check("ken_kbuf_hold", {24'd0, o_kbuf}, {24'd0, kbuf_m});
    kcon = 8'h01;
    repeat (5) @(negedge clk);
    send_frame(8'h1C, 1'b0, 1'b1);

    send_frame(8'h5A, 1'b1, 1'b1);

    // reset mid-frame
    ps2_bit(1'b0);
    ps2_bit(1'b1);
    ps2_bit(1'b1);
    @(negedge clk);
    check("rst_mid_busy_before", {31'd0, o_busy}, 1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("rst_mid_busy", {31'd0, o_busy}, 0);
    check("rst_mid_kbuf", {24'd0, o_kbuf}, 0);
    kbuf_m = 8'h00;
    @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    send_frame(8'h1C, 1'b0, 1'b1);

    repeat (10) @(negedge clk);
    check("sb_empty", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/kbd_receiver.md
KBD_RECEIVER -- requirements
Module: kbd_receiver

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2: synchroniser depth on i_ps2_clk and i_ps2_data.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 12000: maximum i_clk cycles between PS/2 falling edges while mid-frame.
REQ-003 SHALL have port i_clk, input, 1: the single system clock.
REQ-004 SHALL have port i_rst, input, 1: synchronous, active-high reset.
REQ-005 SHALL have port i_kcon, input, 8: current KCON register value. Bit0 is KEN (receiver enable), bit1 is KIE (interrupt enable), bit2 is KRF (receive-full flag, owned by software).
REQ-006 SHALL have port i_ps2_clk, input, 1: keyboard clock, asynchronous to i_clk.
REQ-007 SHALL have port i_ps2_data, input, 1: keyboard data, asynchronous to i_clk.
REQ-008 SHALL have port o_kbuf, output, 8: last accepted scan code.
REQ-009 SHALL have port o_rx_pulse, output, 1: one-cycle strobe when o_kbuf is loaded; the SoC uses it to set KCON.KRF.
REQ-010 SHALL have port o_perr, output, 1: one-cycle strobe on a parity error.
REQ-011 SHALL have port o_ferr, output, 1: one-cycle strobe on a bad stop bit or a timeout.
REQ-012 SHALL have port o_ovr, output, 1: one-cycle strobe on overrun.
REQ-013 SHALL have port o_busy, output, 1: high whenever the FSM is not in IDLE.
REQ-014 SHALL have port o_irq, output, 1: combinational KIE AND KRF.

Function
REQ-015 SHALL pass both PS/2 inputs through SYNC_STAGES flip-flops.
REQ-016 SHALL detect a PS/2 falling edge as previous synced clock = 1 and current synced clock = 0, registered; this gives one "fe" cycle per edge.
REQ-017 SHALL sample synced data only in fe cycles.
REQ-018 SHALL use FSM states IDLE, DATA, PARITY, STOP.
REQ-019 IDLE: fe with data = 0 SHALL go to DATA with the bit counter cleared; fe with data = 1 SHALL stay in IDLE and raise no strobe.
REQ-020 DATA: each fe SHALL shift data in LSB-first; after the 8th bit (counter wraps from 7) the FSM SHALL go to PARITY.
REQ-021 PARITY: fe SHALL latch the parity bit and go to STOP; parity is correct when the 8 data bits plus the parity bit contain an odd number of ones.
REQ-022 STOP: fe SHALL return to IDLE and resolve the frame. Priority, highest first:
- stop bit = 0 → o_ferr
- bad parity → o_perr
- KRF = 1 → o_ovr
- otherwise → load o_kbuf and pulse o_rx_pulse
REQ-023 Strobes SHALL assert in the cycle after the stop-bit fe cycle (latency 1 from fe).
REQ-024 o_kbuf SHALL change only on an accepted frame and hold its value otherwise, including across errors, overrun and KEN = 0.
REQ-025 In any non-IDLE state, TIMEOUT_CYCLES cycles without an fe SHALL force IDLE with an o_ferr pulse; the timeout counter SHALL clear on every fe and in IDLE.
REQ-026 KEN = 0 SHALL force IDLE within 1 cycle, clear the counters and suppress all strobes; this includes KEN dropping mid-frame.
REQ-027 KRF SHALL be sampled in the STOP-resolution cycle only; a KRF change during a frame SHALL have no other effect.
REQ-028 At most one strobe SHALL be high in any cycle.

Reset
REQ-029 i_rst SHALL set: FSM to IDLE, all counters to 0, shift register to 0x00, o_kbuf to 0x00, all strobes to 0, o_busy to 0, and all synchroniser flops to 1 (idle bus level).
REQ-030 Reset mid-frame SHALL discard the partial frame with no strobe.
REQ-031 Because synchroniser flops reset to 1, no fe SHALL be generated on the first cycle after reset.

Structure
REQ-032 The KCON bit positions (KEN = 0, KIE = 1, KRF = 2) and the FSM state encodings SHALL be defined in Defines.v, shared with KCON.
REQ-033 One sub-module, ps2_sync, SHALL contain the synchroniser and falling-edge detector; the FSM, counters and strobes SHALL live in kbd_receiver.

Verification
REQ-034 Send frame 0x1C with parity 0, stop 1, KEN = 1, KRF = 0 → o_kbuf = 0x1C, one o_rx_pulse one cycle after the stop fe, no other strobe.
REQ-035 Send 0xF0 with parity 0 (wrong; correct is 1) → o_perr for one cycle, o_kbuf keeps its previous value 0x1C.
REQ-036 Send 0x1C with stop = 0 → o_ferr; also stop PS/2 clock after 4 data bits with TIMEOUT_CYCLES = 100 → o_ferr exactly 100 cycles after the last fe, then o_busy = 0.
REQ-037 With KRF = 1, send 0x32 with a valid frame → o_ovr for one cycle, o_kbuf unchanged, no o_rx_pulse; with KIE = 1 and KRF = 1, o_irq = 1.
REQ-038 Mid-frame, drop KEN or assert i_rst → next cycle o_busy = 0, no strobe; a following valid 0x1C frame is received correctly.
